fiber_scan_sched: RTL and testbench
===================================

FIBER_SCAN_SCHED -- requirements
Module: fiber_scan_sched

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 15, the number of coordinate-list entries in the tensor store.
REQ-002 SHALL have parameter IDX_W, default 4, the width of row, column and pointer fields.
REQ-003 SHALL have parameter VAL_W, default 8, the width of the data value.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  2  scan request, one bit per requester 0/1; held until granted.
REQ-007 req_sel  in  2  per requester: 0 = scan by row, 1 = scan by column.
REQ-008 req_idx  in  2*IDX_W  per requester target index; requester 0 occupies the low bits.
REQ-009 gnt  out  2  one-cycle grant pulse to the accepted requester.
REQ-010 mem_rd  out  1  store read strobe.
REQ-011 mem_addr  out  IDX_W  store entry pointer.
REQ-012 mem_row, mem_col  in  IDX_W each  entry coordinates, valid the cycle after mem_rd.
REQ-013 mem_val  in  VAL_W  entry value, valid the cycle after mem_rd.
REQ-014 out_valid/out_ready  out/in  1 each  matched-element handshake.
REQ-015 out_val, out_row, out_col, out_id  out  VAL_W/IDX_W/IDX_W/1  matched element fields and owning requester.
REQ-016 done, done_id  out  1 each  one-cycle end-of-scan pulse and owning requester.
REQ-017 match_cnt  out  IDX_W  matches in the last finished scan; present only under the Configuration macro.

Function
REQ-018 SHALL implement FSM IDLE, RD, CMP, EMIT, DONE.
REQ-019 IDLE: when any req bit is set, grant round-robin; the requester not granted last wins ties; gnt pulses the same cycle; latch sel/idx/id; clear ptr; go to RD.
REQ-020 A req bit dropped before its gnt SHALL be ignored; req is not sampled outside IDLE.
REQ-021 RD: mem_rd=1, mem_addr=ptr for exactly one cycle; go to CMP.
REQ-022 CMP: match = (sel==0 ? mem_row : mem_col) == idx.
REQ-023 CMP on match: register out_* from mem_*; set out_valid next cycle; go to EMIT.
REQ-024 CMP on no match: if ptr==NUM_ENTRIES-1 go to DONE, else ptr+1 and go to RD.
REQ-025 EMIT: hold out_valid and fields stable until out_ready=1.
REQ-026 EMIT on handshake: drop out_valid the next cycle; then DONE if ptr==NUM_ENTRIES-1, else ptr+1 and go to RD.
REQ-027 Minimum per-entry cost: 2 cycles without a match; 3 cycles with a match and out_ready held high.
REQ-028 DONE: done=1 and done_id=id for one cycle; return to IDLE; a new grant is possible the following cycle.
REQ-029 ptr SHALL never exceed NUM_ENTRIES-1; no wrap-around read.
REQ-030 mem_rd SHALL be 0 in every state except RD.

Reset
REQ-031 rst low SHALL force, asynchronously: state IDLE, ptr 0, and all outputs 0.
REQ-032 rst low SHALL set the last-granted marker to 1, so requester 0 wins the first tie.
REQ-033 Reset mid-scan SHALL abort with no done pulse; the aborted requester must re-request.

Configuration
REQ-034 Macro SCAN_MATCH_COUNT_EN defined: count matches per scan (cleared at grant) and load match_cnt at DONE; hold it until the next DONE; reset value 0.
REQ-035 Macro SCAN_MATCH_COUNT_EN undefined: no match_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-036 Store rows {1,2,1,3,...} (15 entries); req0 row scan idx 1, out_ready=1 -> outputs for entries 0 and 2 only; done with done_id 0; match_cnt 2 when the macro is defined.
REQ-037 req=2'b11 in the same cycle after reset -> gnt=01 first; after done, gnt=10 -> alternating order.
REQ-038 Column scan idx 5 with no column 5 in the store -> no out_valid; done exactly 31 cycles after gnt (15×2 + 1).
REQ-039 Match on entry 4, out_ready held low 5 cycles -> out_valid and fields stable for 6 cycles; scan then resumes at entry 5.
REQ-040 rst asserted in EMIT -> out_valid=0 immediately; no done pulse; next req0 is granted from entry 0.
REQ-041 Match on entry 14 -> handshake followed directly by done; mem_addr never exceeds 14.

Source files
------------

// File: rtl/fiber_scan_sched_if.sv
// Bus bundle for fiber_scan_sched: requester handshake, store read port and matched-element output.
// match_cnt exists only when SCAN_MATCH_COUNT_EN is defined.
interface fiber_scan_sched_if #(
    parameter int IDX_W = 4,
    parameter int VAL_W = 8
);
    logic [1:0]         req;
    logic [1:0]         req_sel;
    logic [2*IDX_W-1:0] req_idx;
    logic [1:0]         gnt;
    logic               mem_rd;
    logic [IDX_W-1:0]   mem_addr;
    logic [IDX_W-1:0]   mem_row;
    logic [IDX_W-1:0]   mem_col;
    logic [VAL_W-1:0]   mem_val;
    logic               out_valid;
    logic               out_ready;
    logic [VAL_W-1:0]   out_val;
    logic [IDX_W-1:0]   out_row;
    logic [IDX_W-1:0]   out_col;
    logic               out_id;
    logic               done;
    logic               done_id;
`ifdef SCAN_MATCH_COUNT_EN
    logic [IDX_W-1:0]   match_cnt;
`endif

    modport master (
        input  req, req_sel, req_idx, mem_row, mem_col, mem_val, out_ready,
        output gnt, mem_rd, mem_addr, out_valid, out_val, out_row, out_col, out_id,
`ifdef SCAN_MATCH_COUNT_EN
        output match_cnt,
`endif
        output done, done_id
    );

    modport slave (
        output req, req_sel, req_idx, mem_row, mem_col, mem_val, out_ready,
        input  gnt, mem_rd, mem_addr, out_valid, out_val, out_row, out_col, out_id,
`ifdef SCAN_MATCH_COUNT_EN
        input  match_cnt,
`endif
        input  done, done_id
    );
endinterface

// File: rtl/fiber_scan_sched.sv
// Two-requester round-robin scheduler scanning a coordinate-list store by row or column.
// Define SCAN_MATCH_COUNT_EN to add the per-scan match counter on match_cnt.
module fiber_scan_sched #(
    parameter int NUM_ENTRIES = 15,
    parameter int IDX_W       = 4,
    parameter int VAL_W       = 8
) (
    input logic                clk,
    input logic                rst_n,
    fiber_scan_sched_if.master bus
);
    // state | meaning: IDLE arbitrate | RD read strobe | CMP compare entry | EMIT hold output | DONE end pulse
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sel_q, sel_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             ovalid_q, ovalid_d;
    logic             oid_q, oid_d;
    logic [VAL_W-1:0] oval_q, oval_d;
    logic [IDX_W-1:0] orow_q, orow_d;
    logic [IDX_W-1:0] ocol_q, ocol_d;
    logic [1:0]       gnt_c;
    logic             win_id;
    logic             match;
    logic             advance;
`ifdef SCAN_MATCH_COUNT_EN
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] mcnt_q, mcnt_d;
`endif

    // On a tie the requester that was not granted last wins.
    always_comb begin
        if (bus.req == 2'b11) win_id = ~last_q;
        else                  win_id = bus.req[1];
    end

    assign match = ((sel_q ? bus.mem_col : bus.mem_row) == idx_q);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        id_d     = id_q;
        last_d   = last_q;
        ovalid_d = ovalid_q;
        oid_d    = oid_q;
        oval_d   = oval_q;
        orow_d   = orow_q;
        ocol_d   = ocol_q;
        gnt_c    = 2'b00;
        advance  = 1'b0;
`ifdef SCAN_MATCH_COUNT_EN
        cnt_d    = cnt_q;
        mcnt_d   = mcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_c   = win_id ? 2'b10 : 2'b01;
                    sel_d   = bus.req_sel[win_id];
                    idx_d   = win_id ? bus.req_idx[2*IDX_W-1:IDX_W] : bus.req_idx[IDX_W-1:0];
                    id_d    = win_id;
                    last_d  = win_id;
                    ptr_d   = '0;
                    state_d = S_RD;
`ifdef SCAN_MATCH_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_RD: state_d = S_CMP;
            S_CMP: begin
                if (match) begin
                    ovalid_d = 1'b1;
                    oval_d   = bus.mem_val;
                    orow_d   = bus.mem_row;
                    ocol_d   = bus.mem_col;
                    oid_d    = id_q;
                    state_d  = S_EMIT;
`ifdef SCAN_MATCH_COUNT_EN
                    cnt_d    = cnt_q + 1'b1;
`endif
                end else begin
                    advance = 1'b1;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    advance  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SCAN_MATCH_COUNT_EN
                mcnt_d  = cnt_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // The last entry ends the scan instead of wrapping the pointer.
        if (advance) begin
            if (ptr_q == LAST) begin
                state_d = S_DONE;
            end else begin
                ptr_d   = ptr_q + 1'b1;
                state_d = S_RD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            sel_q    <= 1'b0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            ovalid_q <= 1'b0;
            oid_q    <= 1'b0;
            oval_q   <= '0;
            orow_q   <= '0;
            ocol_q   <= '0;
`ifdef SCAN_MATCH_COUNT_EN
            cnt_q    <= '0;
            mcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            id_q     <= id_d;
            last_q   <= last_d;
            ovalid_q <= ovalid_d;
            oid_q    <= oid_d;
            oval_q   <= oval_d;
            orow_q   <= orow_d;
            ocol_q   <= ocol_d;
`ifdef SCAN_MATCH_COUNT_EN
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
`endif
        end
    end

    // Grant is combinational from req, so it is gated to stay low while reset is held.
    assign bus.gnt       = gnt_c & {2{rst_n}};
    assign bus.mem_rd    = (state_q == S_RD);
    assign bus.mem_addr  = ptr_q;
    assign bus.out_valid = ovalid_q;
    assign bus.out_val   = oval_q;
    assign bus.out_row   = orow_q;
    assign bus.out_col   = ocol_q;
    assign bus.out_id    = oid_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.done_id   = (state_q == S_DONE) & id_q;
`ifdef SCAN_MATCH_COUNT_EN
    assign bus.match_cnt = mcnt_q;
`endif
endmodule

// File: tb/tb_fiber_scan_sched.sv
// Directed bench for fiber_scan_sched: table of scans plus tie, stall and mid-scan reset sequences.
// match_cnt checks are compiled in when SCAN_MATCH_COUNT_EN is defined.
module tb_fiber_scan_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   rd_viol = 0;
    int   max_addr = 0;
    logic prev_rd = 1'b0;

    logic [3:0] rows [0:15];
    logic [3:0] cols [0:15];
    logic [7:0] vals [0:15];

    typedef struct {
        int         rq;
        logic       sel;
        logic [3:0] idx;
        logic [14:0] mask;
        int         cycles;
    } vec_t;
    vec_t vecs [6];

    fiber_scan_sched_if #(.IDX_W(4), .VAL_W(8)) bus ();

    fiber_scan_sched #(.NUM_ENTRIES(15), .IDX_W(4), .VAL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Store model: registered read, data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_row <= rows[bus.mem_addr];
            bus.mem_col <= cols[bus.mem_addr];
            bus.mem_val <= vals[bus.mem_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.mem_rd && prev_rd) rd_viol++;
        if (bus.mem_rd && int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
        prev_rd = bus.mem_rd;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts at the negedge of cycle cyc0 after the grant; returns one negedge after done.
    task automatic follow_scan(input int rq, input logic [14:0] mask, input int exp_cyc,
                               input int exp_mc, input string nm, input int cyc0);
        int cyc = cyc0;
        int n = 0;
        int pos = 0;
        bit fin = 0;
        while (!fin && cyc <= 120) begin
            if (bus.out_valid && bus.out_ready) begin
                while (pos < 15 && !mask[pos]) pos++;
                if (pos >= 15) begin
                    chk({nm, "_extra_out"}, 1, 0);
                end else begin
                    chk({nm, "_row"}, bus.out_row, rows[pos]);
                    chk({nm, "_col"}, bus.out_col, cols[pos]);
                    chk({nm, "_val"}, bus.out_val, vals[pos]);
                    chk({nm, "_id"}, bus.out_id, rq);
                    pos++;
                end
                n++;
            end
            if (bus.done) fin = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({nm, "_done_seen"}, fin, 1);
        chk({nm, "_done_cycle"}, cyc, exp_cyc);
        chk({nm, "_done_id"}, bus.done_id, rq);
        chk({nm, "_n_out"}, n, $countones(mask));
        @(negedge clk);
        chk({nm, "_done_pulse"}, bus.done, 0);
`ifdef SCAN_MATCH_COUNT_EN
        chk({nm, "_match_cnt"}, bus.match_cnt, exp_mc);
`else
        if (exp_mc < 0) chk({nm, "_exp_mc"}, exp_mc, 0);
`endif
    endtask

    task automatic set_req(input int rq, input logic sel, input logic [3:0] idx);
        bus.req_sel[rq] = sel;
        if (rq == 0) bus.req_idx[3:0] = idx;
        else         bus.req_idx[7:4] = idx;
        bus.req[rq] = 1'b1;
    endtask

    task automatic run_scan(input int rq, input logic sel, input logic [3:0] idx,
                            input logic [14:0] mask, input int cyc, input string nm);
        @(negedge clk);
        set_req(rq, sel, idx);
        #1 chk({nm, "_gnt"}, bus.gnt, (rq == 0) ? 2'b01 : 2'b10);
        @(negedge clk);
        bus.req[rq] = 1'b0;
        follow_scan(rq, mask, cyc, $countones(mask), nm, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int dcount;
        rst_n         = 1'b1;
        bus.req       = 2'b00;
        bus.req_sel   = 2'b00;
        bus.req_idx   = 8'h00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rows[i] = (i == 0 || i == 2) ? 4'd1 : ((i == 1) ? 4'd2 : 4'(i));
            cols[i] = 4'(i % 4);
            vals[i] = 8'(8'h10 + i);
        end
        vecs[0] = '{0, 1'b0, 4'd1,  15'h0005, 33};
        vecs[1] = '{1, 1'b1, 4'd5,  15'h0000, 31};
        vecs[2] = '{1, 1'b1, 4'd2,  15'h4444, 35};
        vecs[3] = '{0, 1'b0, 4'd14, 15'h4000, 32};
        vecs[4] = '{1, 1'b0, 4'd3,  15'h0008, 32};
        vecs[5] = '{0, 1'b1, 4'd0,  15'h1111, 35};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_val", bus.out_val, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_id", bus.done_id, 0);
`ifdef SCAN_MATCH_COUNT_EN
        chk("rst_match_cnt", bus.match_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie after reset: requester 0 first, then 1, then 0 again.
        set_req(0, 1'b0, 4'd1);
        set_req(1, 1'b0, 4'd2);
        #1 chk("tie_gnt_a", bus.gnt, 2'b01);
        @(negedge clk);
        bus.req[0] = 1'b0;
        follow_scan(0, 15'h0005, 33, 2, "tie_a", 1);
        #1 chk("tie_gnt_b", bus.gnt, 2'b10);
        @(negedge clk);
        bus.req[1] = 1'b0;
        follow_scan(1, 15'h0002, 32, 1, "tie_b", 1);
        set_req(0, 1'b1, 4'd3);
        set_req(1, 1'b0, 4'd2);
        #1 chk("tie_gnt_c", bus.gnt, 2'b01);
        @(negedge clk);
        bus.req = 2'b00;
        follow_scan(0, 15'h0888, 34, 3, "tie_c", 1);
        #1 chk("dropped_req_ignored", bus.gnt, 2'b00);

        for (int v = 0; v < 6; v++)
            run_scan(vecs[v].rq, vecs[v].sel, vecs[v].idx, vecs[v].mask, vecs[v].cycles,
                     $sformatf("vec%0d", v));

        // Back-pressure on entry 4 for five cycles, then resume at entry 5.
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_req(0, 1'b0, 4'd4);
        #1 chk("stall_gnt", bus.gnt, 2'b01);
        @(negedge clk);
        bus.req[0] = 1'b0;
        t = 1;
        while (!bus.out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("stall_valid_cycle", t, 11);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall_valid_%0d", i), bus.out_valid, 1);
            chk($sformatf("stall_val_%0d", i), bus.out_val, 8'h14);
            chk($sformatf("stall_row_%0d", i), bus.out_row, 4'd4);
            if (i == 5) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        chk("stall_drop_valid", bus.out_valid, 0);
        chk("stall_resume_rd", bus.mem_rd, 1);
        chk("stall_resume_addr", bus.mem_addr, 4'd5);
        follow_scan(0, 15'h0000, 37, 1, "stall", 17);

        // Reset while holding an element in EMIT aborts the scan silently.
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_req(1, 1'b0, 4'd3);
        #1 chk("abort_gnt", bus.gnt, 2'b10);
        @(negedge clk);
        bus.req[1] = 1'b0;
        t = 1;
        while (!bus.out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("abort_valid_cycle", t, 9);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_mem_addr", bus.mem_addr, 0);
        chk("abort_done", bus.done, 0);
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.gnt != 2'b00) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        set_req(0, 1'b0, 4'd1);
        #1 chk("abort_regrant", bus.gnt, 2'b01);
        @(negedge clk);
        bus.req[0] = 1'b0;
        chk("abort_first_rd", bus.mem_rd, 1);
        chk("abort_first_addr", bus.mem_addr, 0);
        follow_scan(0, 15'h0005, 33, 2, "abort_rescan", 1);

        chk("max_mem_addr_le_14", (max_addr > 14) ? 1 : 0, 0);
        chk("mem_rd_single_cycle", rd_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
